// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART: FIFO read port plus sticky error flags.
// slave is the receiver, master is the consumer that pops bytes.
interface uart_rx_if;
   logic       rd_uart;
   logic       clr_err;
   logic [7:0] r_data;
   logic       rx_empty;
   logic       rx_full;
   logic       frame_err;
   logic       overrun;

   modport slave (
      input  rd_uart,
      input  clr_err,
      output r_data,
      output rx_empty,
      output rx_full,
      output frame_err,
      output overrun
   );

   modport master (
      output rd_uart,
      output clr_err,
      input  r_data,
      input  rx_empty,
      input  rx_full,
      input  frame_err,
      input  overrun
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a first-word fall-through FIFO.
// Errors are sticky until clr_err; the FSM never stalls on FIFO state.
module uart_rx #(
   parameter int DVSR   = 54,
   parameter int ADDR_W = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     rx,
   uart_rx_if.slave bus
);

   localparam int          DEPTH    = 2 ** ADDR_W;
   localparam logic [15:0] TICK_TOP = 16'(DVSR - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   logic              rx_q1;
   logic              rxs;
   logic [15:0]       cnt;
   logic              s_tick;
   logic [2:0]        state, state_n;
   logic [3:0]        s, s_n;
   logic [2:0]        n, n_n;
   logic [7:0]        b, b_n;
   logic              push;
   logic              fe_set;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W-1:0] wptr_nx, rptr_nx;
   logic              full, empty;
   logic              do_push, do_pop;
   logic              ovr_set;
   logic              frame_err_q, overrun_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_q1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rxs   <= rx_q1;
      end
   end

   // Free-running baud tick; frames never re-phase it.
   assign s_tick = (cnt == TICK_TOP);

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (s_tick)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

   always_comb begin
      state_n = state;
      s_n     = s;
      n_n     = n;
      b_n     = b;
      push    = 1'b0;
      fe_set  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rxs) begin
               state_n = START;
               s_n     = 4'd0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s == 4'd7) begin
                  if (!rxs) begin
                     state_n = DATA;
                     s_n     = 4'd0;
                     n_n     = 3'd0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s + 4'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == 4'd15) begin
                  b_n = {rxs, b[7:1]};
                  s_n = 4'd0;
                  if (n == 3'd7)
                     state_n = STOP;
                  else
                     n_n = n + 3'd1;
               end else begin
                  s_n = s + 4'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s == 4'd15) begin
                  if (rxs) begin
                     push    = 1'b1;
                     state_n = IDLE;
                  end else begin
                     fe_set  = 1'b1;
                     state_n = WAIT_HIGH;
                  end
               end else begin
                  s_n = s + 4'd1;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxs)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         s     <= '0;
         n     <= '0;
         b     <= '0;
      end else begin
         state <= state_n;
         s     <= s_n;
         n     <= n_n;
         b     <= b_n;
      end
   end

   // A full FIFO still accepts a push when the head leaves this cycle.
   assign do_pop  = bus.rd_uart && !empty;
   assign do_push = push && (!full || do_pop);
   assign ovr_set = push && full && !do_pop;
   assign wptr_nx = wptr + 1'b1;
   assign rptr_nx = rptr + 1'b1;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push)
            wptr <= wptr_nx;
         if (do_pop)
            rptr <= rptr_nx;
         if (do_push && !do_pop) begin
            empty <= 1'b0;
            full  <= (wptr_nx == rptr);
         end else if (do_pop && !do_push) begin
            full  <= 1'b0;
            empty <= (rptr_nx == wptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (fe_set)
            frame_err_q <= 1'b1;
         else if (bus.clr_err)
            frame_err_q <= 1'b0;
         if (ovr_set)
            overrun_q <= 1'b1;
         else if (bus.clr_err)
            overrun_q <= 1'b0;
      end
   end

   assign bus.r_data    = empty ? 8'h00 : mem[rptr];
   assign bus.rx_empty  = empty;
   assign bus.rx_full   = full;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx against a frame-level
// queue model of the receive FIFO and its sticky error flags.
module tb_uart_rx;

   localparam int BIT = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rx    = 1'b1;

   uart_rx_if u_if ();

   uart_rx #(
      .DVSR   (4),
      .ADDR_W (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .bus   (u_if.slave)
   );

   always #5 clk = ~clk;

   // Edges since the last reset edge; the free-running tick phase follows it.
   int cyc = 0;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] mq[$];
   logic       m_fe  = 1'b0;
   logic       m_ovr = 1'b0;
   int         f_cyc;
   int         t1;
   int         p_cyc;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".empty"}, 8'(u_if.rx_empty), 8'(mq.size() == 0));
      check({tag, ".full"}, 8'(u_if.rx_full), 8'(mq.size() == 4));
      check({tag, ".data"}, u_if.r_data,
            (mq.size() > 0) ? mq[0] : 8'h00);
      check({tag, ".ferr"}, 8'(u_if.frame_err), 8'(m_fe));
      check({tag, ".ovr"}, 8'(u_if.overrun), 8'(m_ovr));
   endtask

   task automatic m_frame(input logic [7:0] d, input logic stop,
                          input bit pop_same);
      if (!stop) begin
         m_fe = 1'b1;
      end else if (mq.size() == 4) begin
         if (pop_same) begin
            void'(mq.pop_front());
            mq.push_back(d);
         end else begin
            m_ovr = 1'b1;
         end
      end else begin
         mq.push_back(d);
      end
   endtask

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic stop,
                       input int rst_bit, input int hold);
      rx = 1'b0;
      cycles(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         if (i == rst_bit) begin
            cycles(BIT / 2);
            reset = 1'b1;
            cycles(1);
            reset = 1'b0;
            cycles(BIT / 2 - 1);
         end else begin
            cycles(BIT);
         end
      end
      rx = stop;
      cycles(BIT * (1 + hold));
      rx = 1'b1;
   endtask

   task automatic pop();
      u_if.rd_uart = 1'b1;
      cycles(1);
      u_if.rd_uart = 1'b0;
      if (mq.size() > 0)
         void'(mq.pop_front());
   endtask

   task automatic clr();
      u_if.clr_err = 1'b1;
      cycles(1);
      u_if.clr_err = 1'b0;
      m_fe  = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] d);
      send(d, 1'b1, -1, 0);
      m_frame(d, 1'b1, 1'b0);
      cycles(8);
   endtask

   initial begin
      u_if.rd_uart = 1'b0;
      u_if.clr_err = 1'b0;
      cycles(3);
      reset = 1'b0;
      cycles(2);
      check_model("reset");

      send(8'hA5, 1'b1, -1, 0);
      m_frame(8'hA5, 1'b1, 1'b0);
      cycles(8);
      check("a5.byte", u_if.r_data, 8'hA5);
      check_model("a5");
      pop();
      check_model("a5.pop");

      rx = 1'b0;
      cycles(16);
      rx = 1'b1;
      cycles(BIT);
      check_model("glitch");

      send(8'h3C, 1'b0, -1, 19);
      m_frame(8'h3C, 1'b0, 1'b0);
      cycles(8);
      check("3c.ferr", 8'(u_if.frame_err), 8'h01);
      check_model("3c");
      clr();
      check_model("3c.clr");

      // Clearing mid-break must not see a second error from the same break.
      rx = 1'b0;
      cycles(BIT * 12);
      m_fe = 1'b1;
      check_model("brk.mid");
      clr();
      cycles(BIT * 8);
      rx = 1'b1;
      cycles(BIT);
      check_model("brk.end");

      for (int d = 1; d <= 5; d++) begin
         rx_byte(8'(d));
         if (d == 4)
            check("fill.full4", 8'(u_if.rx_full), 8'h01);
         if (d == 5)
            check("fill.ovr5", 8'(u_if.overrun), 8'h01);
         check_model("fill");
      end
      for (int i = 1; i <= 4; i++) begin
         check("drain.byte", u_if.r_data, 8'(i));
         pop();
      end
      check_model("drain");
      clr();

      rx_byte(8'h11);
      rx_byte(8'h22);
      rx_byte(8'h33);
      rx_byte(8'h44);
      f_cyc = cyc;
      t1    = f_cyc + 4;
      while (t1 % 4 != 0)
         t1++;
      p_cyc = t1 + 604;
      fork
         send(8'h77, 1'b1, -1, 0);
         begin
            cycles(p_cyc - 1 - f_cyc);
            u_if.rd_uart = 1'b1;
            cycles(1);
            u_if.rd_uart = 1'b0;
         end
      join
      m_frame(8'h77, 1'b1, 1'b1);
      cycles(8);
      check("same.ovr", 8'(u_if.overrun), 8'h00);
      check("same.full", 8'(u_if.rx_full), 8'h01);
      check_model("same");
      for (int i = 0; i < 4; i++) begin
         pop();
         check_model("same.pop");
      end

      rx_byte(8'h99);
      send(8'hFF, 1'b1, 3, 0);
      mq.delete();
      m_fe  = 1'b0;
      m_ovr = 1'b0;
      cycles(8);
      check_model("rst.mid");
      rx_byte(8'h5A);
      check("rst.5a", u_if.r_data, 8'h5A);
      check_model("rst.next");
      pop();

      for (int k = 0; k < 20; k++) begin
         logic [7:0] d;
         logic       stop;
         int         hold;
         int         npop;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         hold = stop ? 0 : int'($urandom_range(0, 3));
         send(d, stop, -1, hold);
         m_frame(d, stop, 1'b0);
         cycles(4 + int'($urandom_range(0, 20)));
         check_model("rnd.frame");
         npop = int'($urandom_range(0, 32'(mq.size() + 1)));
         for (int i = 0; i < npop; i++) begin
            pop();
            check_model("rnd.pop");
         end
         if ($urandom_range(0, 3) == 0) begin
            clr();
            check_model("rnd.clr");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
